// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: the FSM state encoding
// and the width calculation for the shared dwell counter.
package pll_rst_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    // The counter must reach max(stable, hold) - 1. A width of at least one
    // bit is kept so that a degenerate one-cycle configuration still
    // elaborates.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int m;
        m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        if (m > 1) begin
            return $clog2(m);
        end
        return 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Parameterised multi-flop single-bit synchronizer with async active-high clear.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// Reset sequencer for the 15 MHz domain: synchronizes and debounces the PLL
// lock indicator, holds the system reset until lock has been stable long
// enough, counts lock losses seen while running and supports a soft re-pulse.
module pll_rst_seq
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOSS_W             = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              soft_rst,
    output logic              sys_rst,
    output logic              ready,
    output logic [2:0]        state,
    output logic [LOSS_W-1:0] loss_cnt
);

    localparam int CNT_W = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("pll_rst_seq: SYNC_STAGES must be at least 2");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_chk_stable
        $error("pll_rst_seq: LOCK_STABLE_CYCLES must be at least 1");
    end
    if (RST_HOLD_CYCLES < 1) begin : g_chk_hold
        $error("pll_rst_seq: RST_HOLD_CYCLES must be at least 1");
    end
    if (LOSS_W < 1) begin : g_chk_loss
        $error("pll_rst_seq: LOSS_W must be at least 1");
    end

    logic              locked_s;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOSS_W-1:0] loss_q, loss_d;
    logic              sys_rst_q;
    logic              ready_q;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_locked),
        .q_o (locked_s)
    );

    // Next-state logic: a synchronized lock drop always wins over soft_rst,
    // and the dwell counter is cleared on every transition so it never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            S_RESET: begin
                state_d = S_WAIT_LOCK;
                cnt_d   = '0;
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end else if (soft_rst) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and outputs are all registered; outputs decode the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            loss_q    <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            loss_q    <= loss_d;
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
        end
    end

    assign sys_rst  = sys_rst_q;
    assign ready    = ready_q;
    assign state    = 3'(state_q);
    assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq with SYNC_STAGES=2, LOCK_STABLE_CYCLES=8,
// RST_HOLD_CYCLES=4, LOSS_W=2. Each driven cycle pushes its expected outputs
// onto a scoreboard queue which is popped and compared after the next edge.
module tb_pll_rst_seq;

    localparam int LW = 2;

    typedef struct {
        logic          lk;
        logic          sr;
        logic [2:0]    st;
        logic          sys;
        logic          rdy;
        logic [LW-1:0] loss;
        string         name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          soft_rst;
    logic          sys_rst;
    logic          ready;
    logic [2:0]    state;
    logic [LW-1:0] loss_cnt;

    int   testsRun    = 0;
    int   testsFailed = 0;
    vec_t sbQueue[$];

    // Expected state after each edge, counted from the edge at which a fresh
    // lock rise is first sampled while the FSM is waiting for lock.
    logic [2:0] relockStates [15] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
                                      3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    vec_t powerUpTable [16];

    // 15 MHz clock stand-in; the absolute period does not matter to the DUT.
    always #5 clk = ~clk;

    pll_rst_seq #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .RST_HOLD_CYCLES    (4),
        .LOSS_W             (LW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .state      (state),
        .loss_cnt   (loss_cnt)
    );

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic lk, input logic sr, input logic [2:0] st,
                                input logic sys, input logic rdy, input logic [LW-1:0] loss,
                                input string name);
        vec_t v;
        v.lk = lk; v.sr = sr; v.st = st; v.sys = sys; v.rdy = rdy; v.loss = loss;
        v.name = name;
        return v;
    endfunction

    task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got {st,sys,rdy,loss}=0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sbQueue.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard: output produced with no expectation queued");
            return;
        end
        e = sbQueue.pop_front();
        compare(e.name, {1'b0, state, sys_rst, ready, loss_cnt},
                        {1'b0, e.st, e.sys, e.rdy, e.loss});
    endtask

    task automatic applyStimulus(input vec_t v);
        pll_locked = v.lk;
        soft_rst   = v.sr;
        sbQueue.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Raise lock from WAIT_LOCK and check every edge until release at edge 15.
    task automatic relockRun(input logic [LW-1:0] loss, input string tag);
        for (int e = 0; e < 15; e++) begin
            applyStimulus(mk(1'b1, 1'b0, relockStates[e], (e != 14), (e == 14), loss,
                             $sformatf("%s_edge%0d", tag, e + 1)));
        end
    endtask

    // Drop lock from RUN; the FSM reacts on the third edge.
    task automatic dropLock(input logic [LW-1:0] prevLoss, input logic [LW-1:0] newLoss,
                            input logic softOnThird, input string tag);
        applyStimulus(mk(1'b0, 1'b0, 3'd4, 1'b0, 1'b1, prevLoss, {tag, "_e1"}));
        applyStimulus(mk(1'b0, 1'b0, 3'd4, 1'b0, 1'b1, prevLoss, {tag, "_e2"}));
        applyStimulus(mk(1'b0, softOnThird, 3'd1, 1'b1, 1'b0, newLoss, {tag, "_e3"}));
    endtask

    initial begin
        for (int i = 0; i < 15; i++) begin
            powerUpTable[i] = mk(1'b1, 1'b0, relockStates[i], (i != 14), (i == 14), '0,
                                 $sformatf("powerup_edge%0d", i + 1));
        end
        powerUpTable[15] = mk(1'b1, 1'b0, 3'd4, 1'b0, 1'b1, '0, "powerup_edge16");

        rst        = 1'b1;
        pll_locked = 1'b0;
        soft_rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        compare("reset_values", {1'b0, state, sys_rst, ready, loss_cnt}, {1'b0, 3'd0, 1'b1, 1'b0, 2'd0});

        // Power-up: release reset, lock rises just before edge 1.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(powerUpTable[i]);
        end

        // Soft reset in RUN: exactly four cycles of sys_rst, then RUN.
        applyStimulus(mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, "soft_c1"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_c2"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_c3"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_c4"));
        applyStimulus(mk(1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0, "soft_run"));
        applyStimulus(mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 2'd0, "soft_again"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_again_c2"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_again_c3"));
        applyStimulus(mk(1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 2'd0, "soft_again_c4"));
        applyStimulus(mk(1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 2'd0, "soft_again_run"));

        // Lock loss in RUN, then re-lock.
        dropLock(2'd0, 2'd1, 1'b0, "loss1");
        relockRun(2'd1, "relock1");

        // soft_rst coinciding with the synchronized lock drop: loss wins.
        dropLock(2'd1, 2'd2, 1'b1, "loss_vs_soft");
        relockRun(2'd2, "relock2");

        // Async reset in the middle of HOLD, between clock edges.
        applyStimulus(mk(1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 2'd2, "enter_hold"));
        soft_rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst_mid_hold", {1'b0, state, sys_rst, ready, loss_cnt},
                {1'b0, 3'd0, 1'b1, 1'b0, 2'd0});
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock glitch after five STABLE cycles; full count restarts.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(mk(1'b1, 1'b0, relockStates[i], 1'b1, 1'b0, 2'd0,
                             $sformatf("glitch_pre%0d", i + 1)));
        end
        applyStimulus(mk(1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, "glitch_low"));
        applyStimulus(mk(1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 2'd0, "glitch_back"));
        applyStimulus(mk(1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 2'd0, "glitch_wait"));
        for (int e = 11; e <= 23; e++) begin
            applyStimulus(mk(1'b1, 1'b0, (e <= 18) ? 3'd2 : ((e <= 22) ? 3'd3 : 3'd4),
                             (e != 23), (e == 23), 2'd0, $sformatf("glitch_edge%0d", e)));
        end

        // Loss counter saturation: 1, 2, 3, 3, 3.
        for (int n = 1; n <= 5; n++) begin
            logic [LW-1:0] prevL;
            logic [LW-1:0] newL;
            prevL = LW'((n - 1 > 3) ? 3 : n - 1);
            newL  = LW'((n > 3) ? 3 : n);
            dropLock(prevL, newL, 1'b0, $sformatf("sat_loss%0d", n));
            relockRun(newL, $sformatf("sat_relock%0d", n));
        end

        if (sbQueue.size() != 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sbQueue.size());
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
